// File: rtl/tx_frame_sequencer.sv
// tx_frame_sequencer
//
// Sends an NBYTES-wide frame to a byte-oriented UART transmitter, most
// significant byte first, handshaking on the transmitter's busy flag. Each
// byte can optionally be mapped to a printable ASCII character first.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   i_data     frame to transmit, captured when a send is accepted
//   i_send     one-cycle start request, honoured only while idle
//   i_abort    synchronous cancel of the frame in flight
//   i_tx_busy  busy flag from the UART transmitter
//   o_tx_data  byte presented to the transmitter, held between strobes
//   o_tx_stb   one-cycle transmit strobe
//   o_busy     high from accept until the sequencer is idle again
//   o_done     one-cycle pulse after the last byte has completed
module tx_frame_sequencer #(
  parameter int unsigned NBYTES = 10,
  parameter bit          ENCODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [8*NBYTES-1:0] i_data,
  input  logic                i_send,
  input  logic                i_abort,
  input  logic                i_tx_busy,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_stb,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned FW = 8 * NBYTES;
  localparam int unsigned CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LastIdx = CW'(NBYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStb,
    StWaitHi,
    StWaitLo,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    top_byte;

  // Printable mapping of a 6-bit value: digits, upper case, lower case, '?', '!'.
  function automatic logic [7:0] encode_char(input logic [5:0] v);
    logic [7:0] w;
    w = {2'b00, v};
    if (v < 6'd10) begin
      return w + 8'd48;
    end else if (v < 6'd36) begin
      return w + 8'd55;
    end else if (v < 6'd62) begin
      return w + 8'd61;
    end else if (v == 6'd62) begin
      return 8'd63;
    end else begin
      return 8'd33;
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    top_byte  = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (i_send) begin
          shreg_d = i_data;
          cnt_d   = '0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (!i_tx_busy) begin
          state_d = StStb;
        end
      end
      StStb: begin
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (i_tx_busy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!i_tx_busy) begin
          shreg_d = shreg_q << 8;
          // Counter tops out at NBYTES, which CW bits always hold.
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q < LastIdx) ? StStb : StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides every transition above.
    if (i_abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end

    // Load the output byte on the edge entering STB, from the byte that will
    // be on top of the shift register in that state (post-shift on WAIT_LO).
    if (state_d == StStb) begin
      top_byte  = shreg_d[FW-1 -: 8];
      tx_data_d = ENCODE ? encode_char(top_byte[5:0]) : top_byte;
    end
  end

  assign o_tx_data = tx_data_q;
  assign o_tx_stb  = (state_q == StStb);
  assign o_busy    = (state_q != StIdle);
  assign o_done    = (state_q == StDone);

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Bench for tx_frame_sequencer: one encoding and one raw instance, each with
// a small UART busy model, driven by a vector table plus corner sequences.
module tb_tx_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [79:0] data;
  logic        abort;
  logic        e_send, r_send;
  logic        hold;
  logic [3:0]  e_bcnt, r_bcnt;
  logic        e_tx_busy, r_tx_busy;
  logic [7:0]  e_tx_data, r_tx_data;
  logic        e_stb, r_stb, e_busy, r_busy, e_done, r_done;

  always #5 clk = ~clk;

  tx_frame_sequencer #(.NBYTES(10), .ENCODE(1'b1)) u_enc (
    .clk       (clk),
    .rst       (rst),
    .i_data    (data),
    .i_send    (e_send),
    .i_abort   (abort),
    .i_tx_busy (e_tx_busy),
    .o_tx_data (e_tx_data),
    .o_tx_stb  (e_stb),
    .o_busy    (e_busy),
    .o_done    (e_done)
  );

  tx_frame_sequencer #(.NBYTES(10), .ENCODE(1'b0)) u_raw (
    .clk       (clk),
    .rst       (rst),
    .i_data    (data),
    .i_send    (r_send),
    .i_abort   (abort),
    .i_tx_busy (r_tx_busy),
    .o_tx_data (r_tx_data),
    .o_tx_stb  (r_stb),
    .o_busy    (r_busy),
    .o_done    (r_done)
  );

  // UART model: busy for 3 cycles starting the edge after each strobe.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_bcnt <= 4'd0;
      r_bcnt <= 4'd0;
    end else begin
      if (e_stb) e_bcnt <= 4'd3;
      else if (e_bcnt != 4'd0) e_bcnt <= e_bcnt - 4'd1;
      if (r_stb) r_bcnt <= 4'd3;
      else if (r_bcnt != 4'd0) r_bcnt <= r_bcnt - 4'd1;
    end
  end

  assign e_tx_busy = (e_bcnt != 4'd0) | hold;
  assign r_tx_busy = (r_bcnt != 4'd0);

  // Monitor: shift every strobed byte into an accumulator, count strobes/dones.
  logic [79:0] got [2];
  int          nstb [2];
  int          ndone [2];

  initial begin
    got[0] = '0; got[1] = '0;
    nstb[0] = 0; nstb[1] = 0;
    ndone[0] = 0; ndone[1] = 0;
  end

  always @(negedge clk) begin
    if (e_stb) begin
      got[0] = {got[0][71:0], e_tx_data};
      nstb[0] = nstb[0] + 1;
    end
    if (r_stb) begin
      got[1] = {got[1][71:0], r_tx_data};
      nstb[1] = nstb[1] + 1;
    end
    if (e_done) ndone[0] = ndone[0] + 1;
    if (r_done) ndone[1] = ndone[1] + 1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [79:0] data;
    int          sel;
    logic [79:0] exp;
  } vec_t;

  vec_t vecs [3];

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? e_busy : r_busy;
  endfunction

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input int sel, input logic [79:0] d);
    @(posedge clk); #1;
    data = d;
    if (sel == 0) e_send = 1'b1;
    else          r_send = 1'b1;
    @(posedge clk); #1;
    e_send = 1'b0;
    r_send = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (!busy_of(sel)) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b expected 0", name, busy_of(sel));
    end
  endtask

  task automatic wait_stb(input int sel, input int n, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (nstb[sel] >= n) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for strobe, count=%0d expected %0d", name, nstb[sel], n);
    end
  endtask

  task automatic check_frame(input string name, input int sel, input logic [79:0] exp,
                             input int sb, input int db);
    chk({name, "_nstb"}, 80'(nstb[sel] - sb), 80'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s_byte%0d", name, k), 80'(got[sel][8*(9-k) +: 8]),
          80'(exp[8*(9-k) +: 8]));
    end
    chk({name, "_ndone"}, 80'(ndone[sel] - db), 80'd1);
    chk({name, "_idle"}, 80'(busy_of(sel)), 80'd0);
  endtask

  int sb, db;

  initial begin
    vecs[0] = '{data: 80'h000102030A0B24253E3F, sel: 0, exp: 80'h30313233414261623F21};
    vecs[1] = '{data: 80'h0123456789ABCDEF1122, sel: 1, exp: 80'h0123456789ABCDEF1122};
    vecs[2] = '{data: 80'hC0FF494A7F8009243D1A, sel: 0, exp: 80'h30213941213039617A51};

    rst = 1'b0; data = '0; abort = 1'b0;
    e_send = 1'b0; r_send = 1'b0; hold = 1'b0;

    #12;
    chk("reset_enc", 80'({e_tx_data, e_stb, e_busy, e_done}), 80'd0);
    chk("reset_raw", 80'({r_tx_data, r_stb, r_busy, r_done}), 80'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven full frames.
    for (int v = 0; v < 3; v++) begin
      sb = nstb[vecs[v].sel];
      db = ndone[vecs[v].sel];
      start_frame(vecs[v].sel, vecs[v].data);
      wait_idle(vecs[v].sel, $sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v), vecs[v].sel, vecs[v].exp, sb, db);
    end

    // Transmitter busy at accept: first strobe one cycle after busy falls.
    hold = 1'b1;
    sb = nstb[0]; db = ndone[0];
    start_frame(0, vecs[0].data);
    repeat (5) @(negedge clk);
    chk("hold_nostb", 80'(nstb[0] - sb), 80'd0);
    chk("hold_busy", 80'(e_busy), 80'd1);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    chk("hold_stb_early", 80'(e_stb), 80'd0);
    @(negedge clk);
    chk("hold_stb_first", 80'(e_stb), 80'd1);
    wait_idle(0, "hold");
    check_frame("hold", 0, vecs[0].exp, sb, db);

    // Second send during byte 4 is ignored.
    sb = nstb[0]; db = ndone[0];
    start_frame(0, vecs[2].data);
    wait_stb(0, sb + 4, "resend");
    @(posedge clk); #1;
    e_send = 1'b1;
    @(posedge clk); #1;
    e_send = 1'b0;
    wait_idle(0, "resend");
    check_frame("resend", 0, vecs[2].exp, sb, db);
    repeat (5) @(negedge clk);
    chk("resend_stay_idle", 80'(e_busy), 80'd0);
    chk("resend_no_extra", 80'(nstb[0] - sb), 80'd10);

    // Abort after the third strobe.
    sb = nstb[0]; db = ndone[0];
    start_frame(0, vecs[0].data);
    wait_stb(0, sb + 3, "abort");
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 80'(e_busy), 80'd0);
    repeat (30) @(negedge clk);
    chk("abort_nstb", 80'(nstb[0] - sb), 80'd3);
    chk("abort_ndone", 80'(ndone[0] - db), 80'd0);
    sb = nstb[0]; db = ndone[0];
    start_frame(0, vecs[0].data);
    wait_idle(0, "post_abort");
    check_frame("post_abort", 0, vecs[0].exp, sb, db);

    // Reset during WAIT_LO of byte 6.
    sb = nstb[0]; db = ndone[0];
    start_frame(0, vecs[2].data);
    wait_stb(0, sb + 6, "midrst");
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_outputs", 80'({e_tx_data, e_stb, e_busy, e_done}), 80'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_ndone", 80'(ndone[0] - db), 80'd0);
    sb = nstb[0]; db = ndone[0];
    start_frame(0, vecs[2].data);
    wait_idle(0, "post_rst");
    check_frame("post_rst", 0, vecs[2].exp, sb, db);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_frame_sequencer.md
TX_FRAME_SEQUENCER -- requirements
Module: tx_frame_sequencer

Interface
REQ-001 Parameter: NBYTES, 10, bytes per frame; frame width is 8*NBYTES bits.
REQ-002 Parameter: ENCODE, 1, when 1 each byte is mapped to its printable ASCII character before sending; when 0 bytes are sent raw.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: i_data  input  8*NBYTES  frame to transmit; sampled only at accept.
REQ-006 Port: i_send  input  1  one-cycle start request.
REQ-007 Port: i_abort  input  1  synchronous frame cancel.
REQ-008 Port: i_tx_busy  input  1  busy flag from the UART transmitter.
REQ-009 Port: o_tx_data  output  8  byte presented to the UART transmitter.
REQ-010 Port: o_tx_stb  output  1  one-cycle UART transmit strobe.
REQ-011 Port: o_busy  output  1  high from accept until return to IDLE.
REQ-012 Port: o_done  output  1  one-cycle pulse after the last byte completes.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, ARM, STB, WAIT_HI, WAIT_LO and DONE.
REQ-014 In IDLE with i_send=1, the block SHALL latch i_data into a shift register, clear the byte counter, set o_busy and enter ARM on the next edge (accept).
REQ-015 i_send SHALL be ignored in every state other than IDLE.
REQ-016 ARM SHALL wait until i_tx_busy=0 and then enter STB.
REQ-017 STB SHALL drive o_tx_stb=1 for exactly one cycle with o_tx_data equal to the current top byte (bits [8*NBYTES-1 : 8*NBYTES-8]), and then enter WAIT_HI.
REQ-018 o_tx_data SHALL hold its value from STB until the next STB.
REQ-019 WAIT_HI SHALL remain until i_tx_busy=1 and then enter WAIT_LO.
REQ-020 WAIT_LO SHALL remain until i_tx_busy=0, then on the same edge shift the register left by 8 bits (zero fill) and increment the counter.
REQ-021 On leaving WAIT_LO, the FSM SHALL enter STB if the counter was below NBYTES-1, otherwise DONE.
REQ-022 Bytes SHALL be sent most-significant byte first; exactly NBYTES strobes SHALL be issued per frame.
REQ-023 DONE SHALL assert o_done=1 for one cycle, then enter IDLE with o_busy=0.
REQ-024 i_abort=1 in any non-IDLE state SHALL force IDLE on the next edge with o_busy=0, no o_done pulse and no further strobes; abort SHALL take priority over every other transition.
REQ-025 With ENCODE=1 the low 6 bits v of each byte SHALL map as follows (bits [7:6] ignored): v 0-9 -> v+48; v 10-35 -> v+55; v 36-61 -> v+61; v 62 -> 63 ('?'); v 63 -> 33 ('!').
REQ-026 The counter SHALL be ceil(log2(NBYTES+1)) bits wide and SHALL never wrap within a frame.
REQ-027 The byte encoding SHALL be combinational on the top byte and registered into o_tx_data at STB; latency from accept to the first o_tx_stb SHALL be 2 cycles when i_tx_busy=0.

Reset
REQ-028 While rst=0: the state SHALL be IDLE, the counter 0, the shift register 0, o_tx_data=8'h00, and o_tx_stb=o_busy=o_done=0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no o_done pulse; after release the block SHALL accept a new i_send normally.

Verification
REQ-030 The bench SHALL cover: ENCODE=1, i_data=80'h000102030A0B24253E3F, i_send pulse, UART model busy 3 cycles after each strobe -> 10 strobes carrying '0','1','2','3','A','B','a','b','?','!' in that order, then one o_done pulse.
REQ-031 The bench SHALL cover: ENCODE=0 with i_data=80'h0123456789ABCDEF1122 -> bytes 01,23,45,67,89,AB,CD,EF,11,22 sent raw.
REQ-032 The bench SHALL cover: i_tx_busy held 1 at accept -> no strobe until busy falls, then the first strobe occurs exactly 1 cycle after busy falls.
REQ-033 The bench SHALL cover: a second i_send pulsed during byte 4 -> ignored; exactly 10 strobes and 1 o_done are produced.
REQ-034 The bench SHALL cover: i_abort after the 3rd strobe -> o_busy=0 on the next edge, no further strobes, no o_done; a new frame then completes normally.
REQ-035 The bench SHALL cover: rst pulsed low during WAIT_LO of byte 6 -> all outputs 0 immediately (asynchronously); a subsequent frame sends all 10 bytes from the start.
